// File: rtl/axi_master_pkg.sv
// Shared types and constants for the AXI-style transaction engine.
// Widths, FSM encoding and response codes.
package axi_master_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5
  } state_t;

endpackage

// File: rtl/axi_slave_mem.sv
// 256x8 slave memory with per-byte valid bits.
// Sync write port, combinational read port.
module axi_slave_mem
  import axi_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid
);

  logic [DATA_W-1:0] r_mem [256];
  logic [255:0]      r_valid;

  // data storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // valid bits: cleared on reset, set on write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata  = r_mem[i_raddr];
  assign o_rvalid = r_valid[i_raddr];

endmodule

// File: rtl/axi_master.sv
// Command-driven AXI-style engine: single-beat write, burst read.
// Every transaction terminates in the embedded slave memory.
module axi_master
  import axi_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              en_,
  input  logic              LAST,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [ID_W-1:0]   AWID,
  input  logic [DATA_W-1:0] INDATA,
  output logic              ARVALID,
  output logic [15:0]       OUT,
  output logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RRESP,
  output logic              AWVALID,
  output logic [11:0]       AWOUT,
  output logic              WVALID,
  output logic [DATA_W-1:0] WDATA,
  output logic              WLAST,
  output logic              BREADY,
  output logic [4:0]        BOUT
);

  state_t            r_state;
  logic [LEN_W-1:0]  r_beat;
  logic [ADDR_W-1:0] r_araddr;
  logic [LEN_W-1:0]  r_arlen;
  logic [ID_W-1:0]   r_arid;
  logic [ADDR_W-1:0] r_awaddr;
  logic [ID_W-1:0]   r_awid;
  logic [DATA_W-1:0] r_wdata;
  logic              r_last;

  logic              r_arvalid;
  logic [15:0]       r_out;
  logic              r_rready;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rresp;
  logic              r_awvalid;
  logic [11:0]       r_awout;
  logic              r_wvalid;
  logic [DATA_W-1:0] r_wdata_o;
  logic              r_wlast;
  logic              r_bready;
  logic [4:0]        r_bout;

  logic              w_we;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_rd_off;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_valid;

  // memory port addressed by the beat about to be presented
  always_comb begin
    w_rd_off = 8'd0;
    if (r_state == S_R) w_rd_off = {4'd0, r_beat} + 8'd1;
    w_rd_addr = r_araddr + w_rd_off;
    w_we      = (r_state == S_W) && !rst;
  end

  axi_slave_mem u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we),
    .i_waddr  (r_awaddr),
    .i_wdata  (r_wdata),
    .i_raddr  (w_rd_addr),
    .o_rdata  (w_rd_data),
    .o_rvalid (w_rd_valid)
  );

  // FSM, capture registers and registered channel outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_arvalid <= 1'b0;
      r_out     <= '0;
      r_rready  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 1'b0;
      r_awvalid <= 1'b0;
      r_awout   <= '0;
      r_wvalid  <= 1'b0;
      r_wdata_o <= '0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_bout    <= '0;
    end else begin
      r_arvalid <= 1'b0;
      r_out     <= '0;
      r_rready  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 1'b0;
      r_awvalid <= 1'b0;
      r_awout   <= '0;
      r_wvalid  <= 1'b0;
      r_wdata_o <= '0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_bout    <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (en) begin
            r_araddr  <= ARADDR;
            r_arlen   <= ARLEN;
            r_arid    <= ARID;
            r_arvalid <= 1'b1;
            r_out     <= {ARID, ARLEN, ARADDR};
            r_state   <= S_AR;
          end else if (en_) begin
            r_awaddr  <= AWADDR;
            r_awid    <= AWID;
            r_wdata   <= INDATA;
            r_last    <= LAST;
            r_awvalid <= 1'b1;
            r_awout   <= {AWID, AWADDR};
            r_state   <= S_AW;
          end
        end
        S_AR: begin
          r_beat   <= '0;
          r_rready <= 1'b1;
          r_rdata  <= w_rd_valid ? w_rd_data : '0;
          r_rresp  <= w_rd_valid ? RESP_OKAY : RESP_SLVERR;
          r_state  <= S_R;
        end
        S_R: begin
          if (r_beat == r_arlen) begin
            r_state <= S_IDLE;
          end else begin
            r_beat   <= r_beat + 4'd1;
            r_rready <= 1'b1;
            r_rdata  <= w_rd_valid ? w_rd_data : '0;
            r_rresp  <= w_rd_valid ? RESP_OKAY : RESP_SLVERR;
          end
        end
        S_AW: begin
          r_wvalid  <= 1'b1;
          r_wdata_o <= r_wdata;
          r_wlast   <= r_last;
          r_state   <= S_W;
        end
        S_W: begin
          r_bready <= 1'b1;
          r_bout   <= {r_awid, RESP_OKAY};
          r_state  <= S_B;
        end
        S_B: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ARVALID = r_arvalid;
  assign OUT     = r_out;
  assign RREADY  = r_rready;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
  assign AWVALID = r_awvalid;
  assign AWOUT   = r_awout;
  assign WVALID  = r_wvalid;
  assign WDATA   = r_wdata_o;
  assign WLAST   = r_wlast;
  assign BREADY  = r_bready;
  assign BOUT    = r_bout;

endmodule

// File: tb/tb_axi_master.sv
// Directed bench for axi_master: reset, writes, burst reads,
// address wrap, arbitration, ignored strobes and reset abort.
module tb_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        en_;
  logic        LAST;
  logic [7:0]  ARADDR;
  logic [3:0]  ARLEN;
  logic [3:0]  ARID;
  logic [7:0]  AWADDR;
  logic [3:0]  AWID;
  logic [7:0]  INDATA;
  logic        ARVALID;
  logic [15:0] OUT;
  logic        RREADY;
  logic [7:0]  RDATA;
  logic        RRESP;
  logic        AWVALID;
  logic [11:0] AWOUT;
  logic        WVALID;
  logic [7:0]  WDATA;
  logic        WLAST;
  logic        BREADY;
  logic [4:0]  BOUT;

  int n_cmp = 0;
  int n_bad = 0;

  axi_master dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .en_     (en_),
    .LAST    (LAST),
    .ARADDR  (ARADDR),
    .ARLEN   (ARLEN),
    .ARID    (ARID),
    .AWADDR  (AWADDR),
    .AWID    (AWID),
    .INDATA  (INDATA),
    .ARVALID (ARVALID),
    .OUT     (OUT),
    .RREADY  (RREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .AWVALID (AWVALID),
    .AWOUT   (AWOUT),
    .WVALID  (WVALID),
    .WDATA   (WDATA),
    .WLAST   (WLAST),
    .BREADY  (BREADY),
    .BOUT    (BOUT)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},
        {4'd0, ARVALID, RREADY, AWVALID, WVALID,
         BREADY, 7'd0},
        16'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctl"},
        {4'd0, ARVALID, RREADY, RRESP, AWVALID,
         WVALID, WLAST, BREADY, 5'd0}, 16'd0);
    chk({tag, ".OUT"}, OUT, 16'd0);
    chk({tag, ".RDATA"}, {8'd0, RDATA}, 16'd0);
    chk({tag, ".AWOUT"}, {4'd0, AWOUT}, 16'd0);
    chk({tag, ".WDATA"}, {8'd0, WDATA}, 16'd0);
    chk({tag, ".BOUT"}, {11'd0, BOUT}, 16'd0);
  endtask

  task automatic do_write(input logic [3:0] id,
                          input logic [7:0] a,
                          input logic [7:0] d,
                          input logic       l,
                          input logic [11:0] exp_awout,
                          input logic [4:0]  exp_bout);
    en_ = 1'b1; AWID = id; AWADDR = a;
    INDATA = d; LAST = l;
    tick();
    en_ = 1'b0;
    chk("wr.AWVALID", {15'd0, AWVALID}, 16'd1);
    chk("wr.AWOUT", {4'd0, AWOUT}, {4'd0, exp_awout});
    tick();
    chk("wr.WVALID", {15'd0, WVALID}, 16'd1);
    chk("wr.WDATA", {8'd0, WDATA}, {8'd0, d});
    chk("wr.WLAST", {15'd0, WLAST}, {15'd0, l});
    tick();
    chk("wr.BREADY", {15'd0, BREADY}, 16'd1);
    chk("wr.BOUT", {11'd0, BOUT}, {11'd0, exp_bout});
    tick();
    chk_idle("wr.end");
  endtask

  task automatic start_read(input logic [3:0] id,
                            input logic [3:0] len,
                            input logic [7:0] a,
                            input logic [15:0] exp_out);
    en = 1'b1; ARID = id; ARLEN = len; ARADDR = a;
    tick();
    en = 1'b0;
    chk("rd.ARVALID", {15'd0, ARVALID}, 16'd1);
    chk("rd.OUT", OUT, exp_out);
    tick();
  endtask

  task automatic beat(input string tag,
                      input logic [7:0] d,
                      input logic r);
    chk({tag, ".RREADY"}, {15'd0, RREADY}, 16'd1);
    chk({tag, ".RDATA"}, {8'd0, RDATA}, {8'd0, d});
    chk({tag, ".RRESP"}, {15'd0, RRESP}, {15'd0, r});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en_ = 1'b0; LAST = 1'b0;
    ARADDR = '0; ARLEN = '0; ARID = '0;
    AWADDR = '0; AWID = '0; INDATA = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    start_read(4'h0, 4'h0, 8'h00, 16'h0000);
    beat("rd0", 8'h00, 1'b1);
    tick();
    chk_idle("rd0.end");

    do_write(4'h1, 8'h01, 8'h01, 1'b0, 12'h101, 5'b00010);
    do_write(4'h2, 8'h02, 8'h02, 1'b0, 12'h202, 5'b00100);
    do_write(4'h1, 8'h01, 8'h01, 1'b1, 12'h101, 5'b00010);

    start_read(4'h1, 4'h3, 8'h01, 16'h1301);
    beat("b0", 8'h01, 1'b0);
    en_ = 1'b1; AWADDR = 8'h50; AWID = 4'h7;
    INDATA = 8'h99;
    tick();
    en_ = 1'b0;
    beat("b1", 8'h02, 1'b0);
    tick();
    beat("b2", 8'h00, 1'b1);
    tick();
    beat("b3", 8'h00, 1'b1);
    tick();
    chk_idle("burst.end");
    tick();
    chk("ignored.AWVALID", {15'd0, AWVALID}, 16'd0);

    do_write(4'h3, 8'hFF, 8'hAA, 1'b0, 12'h3FF, 5'b00110);
    do_write(4'h4, 8'h00, 8'hBB, 1'b0, 12'h400, 5'b01000);
    start_read(4'h5, 4'h1, 8'hFF, 16'h51FF);
    beat("wrap0", 8'hAA, 1'b0);
    tick();
    beat("wrap1", 8'hBB, 1'b0);
    tick();
    chk_idle("wrap.end");

    en = 1'b1; en_ = 1'b1;
    ARID = 4'h3; ARLEN = 4'h0; ARADDR = 8'h02;
    AWID = 4'h6; AWADDR = 8'h10; INDATA = 8'h55;
    tick();
    en = 1'b0; en_ = 1'b0;
    chk("arb.ARVALID", {15'd0, ARVALID}, 16'd1);
    chk("arb.AWVALID", {15'd0, AWVALID}, 16'd0);
    chk("arb.OUT", OUT, 16'h3002);
    tick();
    beat("arb.b0", 8'h02, 1'b0);
    chk("arb.AWVALID2", {15'd0, AWVALID}, 16'd0);
    tick();
    chk_idle("arb.end");
    start_read(4'h0, 4'h0, 8'h10, 16'h0010);
    beat("drop", 8'h00, 1'b1);
    tick();

    en_ = 1'b1; AWID = 4'h2; AWADDR = 8'h20;
    INDATA = 8'h77; LAST = 1'b0;
    tick();
    en_ = 1'b0;
    chk("abort.AWVALID", {15'd0, AWVALID}, 16'd1);
    tick();
    chk("abort.WVALID", {15'd0, WVALID}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("abort");
    start_read(4'h0, 4'h0, 8'h20, 16'h0020);
    beat("abort.rd", 8'h00, 1'b1);
    tick();
    chk_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
